gmii_pkt_monitor: RTL

Synthesizable GMII transmit-side receiver/checker that sits on a bridge output port (gmii_tx_dv_N / gmii_txd_N). It is the receiving end of the frames the GMII drivers inject. It strips preamble/SFD, captures DA/SA, counts frame length, and checks FCS. One status record per frame is delivered on an srdy/drdy interface to a scoreboard or stats block.

---
 rtl/gmii_pkg.sv | 46 ++++
 rtl/gmii_pkt_monitor_if.sv | 27 ++
 rtl/gmii_crc32.sv | 26 ++
 rtl/gmii_pkt_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared constants, state encoding and CRC helper for the GMII frame monitor
// and the planned GMII-side frame generator.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  // Status record field widths
  localparam int MAC_W = 48;
  localparam int LEN_W = 16;

  // Preamble bookkeeping: more than PRE_MAX preamble bytes is malformed
  localparam int          PRE_CNT_W = 4;
  localparam logic [3:0]  PRE_MAX   = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DA,
    ST_SA,
    ST_BODY,
    ST_DROP
  } state_t;

  // One byte of the IEEE 802.3 CRC32. Wire bits enter LSB first, which is
  // the reflected CRC; the register is kept in non-reflected (MSB-first)
  // orientation, so a frame with a good FCS leaves exactly CRC_RESIDUE.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_pkt_monitor_if.sv
// Per-frame status record channel: srdy/drdy handshake plus record fields.
interface gmii_pkt_monitor_if;
  import gmii_pkg::*;

  logic             p_srdy;
  logic             p_drdy;
  logic [MAC_W-1:0] p_da;
  logic [MAC_W-1:0] p_sa;
  logic [LEN_W-1:0] p_len;
  logic             p_crc_ok;
  logic             p_runt;
  logic             p_giant;
  logic             p_pre_err;

  // Monitor side: produces records
  modport master (
    output p_srdy, p_da, p_sa, p_len, p_crc_ok, p_runt, p_giant, p_pre_err,
    input  p_drdy
  );

  // Consumer side: scoreboard or stats block
  modport slave (
    input  p_srdy, p_da, p_sa, p_len, p_crc_ok, p_runt, p_giant, p_pre_err,
    output p_drdy
  );

endinterface

// File: rtl/gmii_crc32.sv
// Byte-wise CRC32 accumulator; init has priority over en.
module gmii_crc32
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] r_crc;

  // Restart on reset/init, otherwise fold in one byte when enabled
  always_ff @(posedge clk) begin
    if (reset || init) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc32_byte(r_crc, d);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/gmii_pkt_monitor.sv
// GMII transmit-side frame checker: strips preamble/SFD, captures DA/SA,
// counts length, checks FCS and emits one status record per frame.
module gmii_pkt_monitor
  import gmii_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gmii_tx_dv,
  input  logic [7:0]         gmii_txd,
  gmii_pkt_monitor_if.master p_if,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   ovf_cnt
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_wait_dv_low;
  logic [PRE_CNT_W-1:0] r_pre_cnt;
  logic [2:0]           r_byte_idx;
  logic [LEN_W-1:0]     r_len;
  logic [MAC_W-1:0]     r_da;
  logic [MAC_W-1:0]     r_sa;

  logic                 r_srdy;
  logic [MAC_W-1:0]     r_p_da;
  logic [MAC_W-1:0]     r_p_sa;
  logic [LEN_W-1:0]     r_p_len;
  logic                 r_p_crc_ok;
  logic                 r_p_runt;
  logic                 r_p_giant;
  logic                 r_p_pre_err;
  logic [CNT_W-1:0]     r_pkt_cnt;
  logic [CNT_W-1:0]     r_ovf_cnt;

  logic                 w_count;
  logic                 w_frame_end;
  logic                 w_pre_start;
  logic                 w_pre_inc;
  logic                 w_load;
  logic                 w_ovf;
  logic [31:0]          w_crc;
  logic                 w_in_payload;
  logic                 w_rec_crc_ok;
  logic                 w_rec_pre_err;
  logic [5:0]           w_lane;

  // FCS accumulator covers every byte that is counted in the length
  gmii_crc32 u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (w_frame_end),
    .en    (w_count),
    .d     (gmii_txd),
    .crc   (w_crc)
  );

  // Address byte lane decode: byte idx 0 lands in bits [47:40]
  for (genvar gi = 0; gi < 6; gi++) begin : g_lane
    assign w_lane[gi] = (r_byte_idx == 3'(gi));
  end

  // Next-state and per-byte strobes
  always_comb begin
    w_state_next = r_state;
    w_count      = 1'b0;
    w_frame_end  = 1'b0;
    w_pre_start  = 1'b0;
    w_pre_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // After a reset mid-frame, the rest of that frame is skipped
        if (gmii_tx_dv && !r_wait_dv_low) begin
          if (gmii_txd == PREAMBLE_BYTE) begin
            w_state_next = ST_PRE;
            w_pre_start  = 1'b1;
          end else begin
            w_state_next = ST_DROP;
          end
        end
      end
      ST_PRE: begin
        if (!gmii_tx_dv) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end else if (gmii_txd == PREAMBLE_BYTE) begin
          if (r_pre_cnt >= PRE_MAX) begin
            w_state_next = ST_DROP;
          end else begin
            w_pre_inc = 1'b1;
          end
        end else if (gmii_txd == SFD_BYTE) begin
          w_state_next = ST_DA;
        end else begin
          w_state_next = ST_DROP;
        end
      end
      ST_DA, ST_SA: begin
        if (!gmii_tx_dv) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end else begin
          w_count = 1'b1;
          if (r_byte_idx == 3'd5) begin
            w_state_next = (r_state == ST_DA) ? ST_SA : ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (!gmii_tx_dv) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      ST_DROP: begin
        if (!gmii_tx_dv) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register plus preamble, address-index and length counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_wait_dv_low <= gmii_tx_dv;
      r_pre_cnt     <= '0;
      r_byte_idx    <= '0;
      r_len         <= '0;
    end else begin
      r_state <= w_state_next;
      if (!gmii_tx_dv) begin
        r_wait_dv_low <= 1'b0;
      end
      if (w_pre_start) begin
        r_pre_cnt <= PRE_CNT_W'(1);
      end else if (w_pre_inc) begin
        r_pre_cnt <= r_pre_cnt + PRE_CNT_W'(1);
      end else if (w_frame_end) begin
        r_pre_cnt <= '0;
      end
      if (w_frame_end) begin
        r_byte_idx <= '0;
        r_len      <= '0;
      end else if (w_count) begin
        if (r_state != ST_BODY) begin
          r_byte_idx <= (r_byte_idx == 3'd5) ? 3'd0 : r_byte_idx + 3'd1;
        end
        if (r_len != {LEN_W{1'b1}}) begin
          r_len <= r_len + LEN_W'(1);
        end
      end
    end
  end

  // DA/SA capture, positional so short frames leave low bytes at zero
  always_ff @(posedge clk) begin
    if (reset || w_frame_end) begin
      r_da <= '0;
      r_sa <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_count && (r_state == ST_DA) && w_lane[i]) begin
          r_da[47-8*i -: 8] <= gmii_txd;
        end
        if (w_count && (r_state == ST_SA) && w_lane[i]) begin
          r_sa[47-8*i -: 8] <= gmii_txd;
        end
      end
    end
  end

  // Only frames that got past the SFD can carry a good FCS
  assign w_in_payload  = (r_state == ST_DA) || (r_state == ST_SA) || (r_state == ST_BODY);
  assign w_rec_crc_ok  = w_in_payload && (w_crc == CRC_RESIDUE);
  assign w_rec_pre_err = (r_state == ST_PRE) || (r_state == ST_DROP);

  // A new record may replace one that is being consumed on the same edge
  assign w_load = w_frame_end && (!r_srdy || p_if.p_drdy);
  assign w_ovf  = w_frame_end && r_srdy && !p_if.p_drdy;

  // Status record holding register and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_srdy      <= 1'b0;
      r_p_da      <= '0;
      r_p_sa      <= '0;
      r_p_len     <= '0;
      r_p_crc_ok  <= 1'b0;
      r_p_runt    <= 1'b0;
      r_p_giant   <= 1'b0;
      r_p_pre_err <= 1'b0;
    end else if (w_load) begin
      r_srdy      <= 1'b1;
      r_p_da      <= r_da;
      r_p_sa      <= r_sa;
      r_p_len     <= r_len;
      r_p_crc_ok  <= w_rec_crc_ok;
      r_p_runt    <= (r_len < LEN_W'(MIN_LEN));
      r_p_giant   <= (r_len > LEN_W'(MAX_LEN));
      r_p_pre_err <= w_rec_pre_err;
    end else if (r_srdy && p_if.p_drdy) begin
      r_srdy <= 1'b0;
    end
  end

  // Frame and dropped-record counters, both wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_frame_end) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
      if (w_ovf) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign p_if.p_srdy    = r_srdy;
  assign p_if.p_da      = r_p_da;
  assign p_if.p_sa      = r_p_sa;
  assign p_if.p_len     = r_p_len;
  assign p_if.p_crc_ok  = r_p_crc_ok;
  assign p_if.p_runt    = r_p_runt;
  assign p_if.p_giant   = r_p_giant;
  assign p_if.p_pre_err = r_p_pre_err;
  assign pkt_cnt        = r_pkt_cnt;
  assign ovf_cnt        = r_ovf_cnt;

endmodule
